// File: rtl/alu_acc.sv
// Handshaked ALU with a persistent carry register for add-with-carry chaining
// and an iterative shift-add multiplier producing a double-width product.
module alu_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_ADC  = 4'hC;
  localparam logic [3:0] OP_PASS = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   alu_res;
  logic               c, z, n, v, e;

  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_next;

  assign out_valid = (state == HOLD);
  assign in_ready  = (state != BUSY) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // The carry output register doubles as carry_reg, feeding ADC.
  always_comb begin
    sum  = '0;
    opnd = b;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    e    = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC, OP_INC: begin
        opnd = (opcode == OP_INC) ? WIDTH'(1) : b;
        sum  = {1'b0, a} + {1'b0, opnd}
             + {{WIDTH{1'b0}}, (opcode == OP_ADC) ? carry : 1'b0};
        r    = sum[WIDTH-1:0];
        c    = sum[WIDTH];
        v    = (a[WIDTH-1] == opnd[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        opnd = (opcode == OP_DEC) ? WIDTH'(1) : b;
        sum  = {1'b0, a} - {1'b0, opnd};
        r    = sum[WIDTH-1:0];
        c    = sum[WIDTH];
        v    = (a[WIDTH-1] != opnd[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL: begin
        r = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        r = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      OP_PASS: r = b;
      OP_MUL:  r = '0;
      default: e = 1'b1;
    endcase
    z       = !e && (r == '0);
    n       = r[WIDTH-1];
    alu_res = (opcode == OP_CMP) ? '0 : r;
  end

  // One shift-add step: conditionally add the multiplicand into the high
  // half, then shift the whole product right, consuming one multiplier bit.
  always_comb begin
    psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {psum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      res    <= '0;
      res_hi <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        state <= BUSY;
        cnt   <= CW'(WIDTH);
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
      end else begin
        state  <= HOLD;
        res    <= alu_res;
        res_hi <= '0;
        carry  <= c;
        zero   <= z;
        neg    <= n;
        ovf    <= v;
        err    <= e;
      end
    end else if (state == BUSY) begin
      prod <= prod_next;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state  <= HOLD;
        res    <= prod_next[WIDTH-1:0];
        res_hi <= prod_next[2*WIDTH-1:WIDTH];
        carry  <= (prod_next[2*WIDTH-1:WIDTH] != '0);
        zero   <= (prod_next == '0);
        neg    <= prod_next[2*WIDTH-1];
        ovf    <= 1'b0;
        err    <= 1'b0;
      end
    end else if (state == HOLD && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_alu_acc.sv
// Directed, table-driven bench for alu_acc (WIDTH=8) with hand-sequenced
// multiplier, backpressure and reset-during-multiply scenarios.
module tb_alu_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res, res_hi;
  logic       carry, zero, neg, ovf, err;

  int total  = 0;
  int passed = 0;

  alu_acc #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .carry(carry), .zero(zero), .neg(neg),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // flags packed as {carry, zero, neg, ovf, err}
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [4:0] flags;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] op,
                                input logic [7:0] ia, input logic [7:0] ib);
    in_valid = v;
    opcode   = op;
    a        = ia;
    b        = ib;
  endtask

  task automatic check_output(input string name, input logic [7:0] er,
                              input logic [7:0] eh, input logic [4:0] ef);
    check({name, " out_valid"}, out_valid, 1);
    check({name, " res"}, res, er);
    check({name, " res_hi"}, res_hi, eh);
    check({name, " flags"}, {carry, zero, neg, ovf, err}, ef);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen_valid;

    vecs[0]  = '{4'h0, 8'h14, 8'h4F, 8'h63, 5'b00000};
    vecs[1]  = '{4'h1, 8'h14, 8'h4F, 8'hC5, 5'b10100};
    vecs[2]  = '{4'h2, 8'h14, 8'h4F, 8'h04, 5'b00000};
    vecs[3]  = '{4'h3, 8'h14, 8'h4F, 8'h5F, 5'b00000};
    vecs[4]  = '{4'h4, 8'h14, 8'h4F, 8'h5B, 5'b00000};
    vecs[5]  = '{4'h5, 8'h14, 8'h4F, 8'hEB, 5'b00100};
    vecs[6]  = '{4'h6, 8'h14, 8'h4F, 8'h28, 5'b00000};
    vecs[7]  = '{4'h7, 8'h14, 8'h4F, 8'h0A, 5'b00000};
    vecs[8]  = '{4'h8, 8'h14, 8'h4F, 8'h15, 5'b00000};
    vecs[9]  = '{4'h9, 8'h14, 8'h4F, 8'h13, 5'b00000};
    vecs[10] = '{4'hB, 8'h14, 8'h4F, 8'h00, 5'b10100};
    vecs[11] = '{4'hC, 8'h14, 8'h4F, 8'h64, 5'b00000};
    vecs[12] = '{4'hD, 8'h14, 8'h4F, 8'h4F, 5'b00000};
    vecs[13] = '{4'h0, 8'hFF, 8'h01, 8'h00, 5'b11000};
    vecs[14] = '{4'hC, 8'h00, 8'h00, 8'h01, 5'b00000};
    vecs[15] = '{4'h0, 8'h7F, 8'h01, 8'h80, 5'b00110};
    vecs[16] = '{4'hB, 8'h33, 8'h33, 8'h00, 5'b01000};
    vecs[17] = '{4'h6, 8'h81, 8'h00, 8'h02, 5'b10000};
    vecs[18] = '{4'h7, 8'h01, 8'h00, 8'h00, 5'b11000};
    vecs[19] = '{4'h9, 8'h00, 8'h00, 8'hFF, 5'b10100};
    vecs[20] = '{4'h8, 8'hFF, 8'h00, 8'h00, 5'b11000};
    vecs[21] = '{4'h1, 8'h80, 8'h01, 8'h7F, 5'b00010};
    vecs[22] = '{4'hE, 8'h14, 8'h4F, 8'h00, 5'b00001};
    vecs[23] = '{4'hF, 8'h55, 8'hAA, 8'h00, 5'b00001};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 4'h0, 8'h00, 8'h00);
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset res", {res_hi, res}, 0);
    check("reset flags", {carry, zero, neg, ovf, err}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset in_ready", in_ready, 1);

    // Back-to-back sweep, one result per cycle.
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d in_ready", i), in_ready, 1);
      tick();
      check_output($sformatf("v%0d", i), vecs[i].res, 8'h00, vecs[i].flags);
    end

    // Multiply; operands change and an ignored request is held meanwhile.
    apply_stimulus(1'b1, 4'hA, 8'h14, 8'h4F);
    check("mul accept in_ready", in_ready, 1);
    tick();
    apply_stimulus(1'b1, 4'h0, 8'h01, 8'h01);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mul busy%0d in_ready", k), in_ready, 0);
      check($sformatf("mul busy%0d out_valid", k), out_valid, 0);
      tick();
    end
    check_output("mul", 8'h2C, 8'h06, 5'b10000);
    tick();
    check_output("post-mul add", 8'h02, 8'h00, 5'b00000);

    // Backpressure: result frozen, pending request held off, then one transfer.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 4'h0, 8'h10, 8'h20);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output($sformatf("bp%0d", k), 8'h02, 8'h00, 5'b00000);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check_output("bp release", 8'h30, 8'h00, 5'b00000);
    apply_stimulus(1'b0, 4'h0, 8'h00, 8'h00);
    tick();
    check("bp drained out_valid", out_valid, 0);

    // Reset in the 4th multiply cycle after a carry-producing result.
    apply_stimulus(1'b1, 4'h0, 8'hFF, 8'h02);
    tick();
    check_output("pre-rst add", 8'h01, 8'h00, 5'b10000);
    apply_stimulus(1'b1, 4'hA, 8'h14, 8'h4F);
    tick();
    apply_stimulus(1'b0, 4'h0, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst mid-mul out_valid", out_valid, 0);
    check("rst mid-mul res", {res_hi, res}, 0);
    check("rst mid-mul flags", {carry, zero, neg, ovf, err}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst release in_ready", in_ready, 1);
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("no stale product", seen_valid, 0);
    apply_stimulus(1'b1, 4'hC, 8'h00, 8'h00);
    tick();
    check_output("adc after rst", 8'h00, 8'h00, 5'b01000);
    apply_stimulus(1'b0, 4'h0, 8'h00, 8'h00);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
# alu_acc

Parametrised, handshaked successor to the 8-bit combinational ALU. It accepts one operation per transfer on a valid/ready input port and returns a registered result plus flags on a valid/ready output port. A persistent flags register supports add-with-carry chaining, and an iterative shift-add multiplier supplies a full double-width product. The block sits between an operand/opcode source (sequencer or register file) and a result sink.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept a request this cycle
- opcode  input  4  operation select
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result/flags valid
- out_ready  input  1  sink accepts result this cycle
- res  output  WIDTH  result (low half of product for MUL)
- res_hi  output  WIDTH  high half of product for MUL; 0 for all other ops
- carry, zero, neg, ovf, err  output  1 each  flags of the presented result

## Operation
- Opcodes (results are truncated to WIDTH unless noted):
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND, 3 OR, 4 XOR
  - 5 NOT: ~a
  - 6 SHL: a<<1
  - 7 SHR: a>>1 (logical)
  - 8 INC: a+1
  - 9 DEC: a-1
  - A MUL: unsigned a*b; {res_hi,res} = 2·WIDTH-bit product
  - B CMP: flags of a-b, res=0
  - C ADC: a+b+carry_reg
  - D PASS: b
  - E/F: invalid
- Flag rules:
  - carry: adder carry-out (ADD/ADC/INC); borrow, i.e. a<b unsigned (SUB/CMP/DEC); shifted-out bit (SHL: a[W-1], SHR: a[0]); MUL: res_hi≠0; all others 0.
  - zero: res==0; for MUL, the whole product ==0.
  - neg: res[WIDTH-1]; for MUL, res_hi[WIDTH-1].
  - ovf: signed overflow for ADD/SUB/CMP/ADC/INC/DEC; 0 otherwise.
  - err: 1 only for opcodes E/F. On E/F, res=res_hi=0, other flags 0.
- carry_reg holds the carry of the most recently produced result. It updates at the same edge that loads res. Reset value 0.
- State machine:
  - IDLE: no result pending.
  - BUSY: MUL iterating.
  - HOLD: result presented and waiting for out_ready.
- Transitions:
  - IDLE/HOLD → accept of a single-cycle op → HOLD, result loaded.
  - IDLE/HOLD → accept of MUL → BUSY, iteration counter = WIDTH.
  - BUSY → counter reaches 0 → HOLD, product loaded.
  - HOLD → out_ready with no accept → IDLE.
- in_ready = (state≠BUSY) && (!out_valid || out_ready). Simultaneous output drain and new accept is allowed (back-to-back).
- Multiplier: one shift-add step per cycle. Operands are latched at accept, so a/b/opcode may change afterwards.

## Timing
- Reset (async assert, sync-released use): out_valid=0, state=IDLE, res=res_hi=0, all flags 0, carry_reg=0, in_ready=1 after release.
- Single-cycle op accepted at edge N: out_valid=1 and res/flags valid from edge N until the edge where out_valid&&out_ready.
- Sustained throughput is 1 op/cycle with out_ready held high.
- MUL accepted at edge N:
  - in_ready=0 and out_valid=0 during cycles N..N+WIDTH-1. The previous result must already be drained; in_ready guarantees this.
  - out_valid rises at edge N+WIDTH.
  - Latency is WIDTH cycles and throughput is 1 MUL per WIDTH+1 cycles at best.
- Backpressure: while out_valid && !out_ready, res/res_hi/flags are stable and in_ready=0.
- ADC uses carry_reg as of its accept edge, i.e. the carry of the previous result, even if that result is still in HOLD.
- Reset mid-BUSY or mid-HOLD: the operation is discarded immediately, with no out_valid pulse after release.
- in_valid while in_ready=0: the request is ignored. The source must hold it stable.

## Test plan
- WIDTH=8, a=0x14, b=0x4F, out_ready=1, then sweep opcodes 0–D back-to-back. Required responses:
  - ADD: res=0x63, carry=0, ovf=0.
  - SUB: res=0xC5, carry=1, neg=1.
  - AND: 0x04. OR: 0x5F. XOR: 0x5B. NOT: 0xEB. SHL: 0x28. SHR: 0x0A. INC: 0x15. DEC: 0x13.
  - One result per cycle.
- MUL a=0x14, b=0x4F accepted at edge N: in_ready=0 for 8 cycles, then out_valid at N+8 with res_hi=0x06, res=0x2C, carry=1.
- Carry chain: ADD 0xFF+0x01 gives res=0x00, carry=1, zero=1. Next ADC 0x00+0x00 gives res=0x01, carry=0. ADD 0x7F+0x01 gives res=0x80, ovf=1, neg=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD. Required: res/flags constant, in_ready=0, no request lost. Release gives exactly one transfer.
- Opcode 0xE → err=1, res=0, other flags 0. Opcode 0xB with a=b=0x33 → zero=1, res=0.
- Assert rst_n=0 in the 4th MUL cycle. Required: out_valid=0 and flags=0 immediately, in_ready=1 after release, and no stale product is ever presented.
